// File: rtl/sub_pkg.sv
// Shared types and helpers for the serial subtractor.
// Holds the FSM state encoding and the counter sizing function.
package sub_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Ceiling log2, never narrower than one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sub_chain_k.sv
// K-bit ripple chain of one-bit full-subtractor cells (combinational).
// Ports: x, y, bi in; d, bo, b_msb_in (borrow entering the top cell) out.
module sub_chain_k #(
  parameter int K = 1
) (
  input  logic [K-1:0] x,
  input  logic [K-1:0] y,
  input  logic         bi,
  output logic [K-1:0] d,
  output logic         bo,
  output logic         b_msb_in
);

  logic [K:0] br;

  assign br[0] = bi;

  for (genvar i = 0; i < K; i++) begin : g_cell
    assign d[i]    = x[i] ^ y[i] ^ br[i];
    assign br[i+1] = (~x[i] & y[i])
                   | (~(x[i] ^ y[i]) & br[i]);
  end

  assign bo       = br[K];
  assign b_msb_in = br[K-1];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle a - b - bin, K bits per clock, LSB slice first.
// Ports: clk, rst, start, a, b, bin in; busy, done, diff, bout, ovf, zero out.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int K     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int S  = WIDTH / K;
  localparam int CW = clog2(S);
  localparam logic [CW-1:0] LAST = CW'(S - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             br_q;

  logic [31:0]      base;
  logic [K-1:0]     x;
  logic [K-1:0]     y;
  logic [K-1:0]     d;
  logic             bo;
  logic             bm;
  logic             last;
  logic [WIDTH-1:0] diff_nx;

  assign base = 32'(cnt) * 32'(K);
  assign x    = a_q[base +: K];
  assign y    = b_q[base +: K];
  assign last = (cnt == LAST);

  sub_chain_k #(
    .K(K)
  ) u_chain (
    .x       (x),
    .y       (y),
    .bi      (br_q),
    .d       (d),
    .bo      (bo),
    .b_msb_in(bm)
  );

  // diff with the current slice merged in; used for the zero flag.
  always_comb begin
    diff_nx = diff;
    diff_nx[base +: K] = d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      br_q  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            br_q  <= bin;
            cnt   <= '0;
            diff  <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          diff <= diff_nx;
          br_q <= bo;
          cnt  <= cnt + 1'b1;
          if (last) begin
            bout  <= bo;
            ovf   <= bm ^ bo;
            zero  <= (diff_nx == '0);
            done  <= 1'b1;
            busy  <= 1'b0;
            cnt   <= '0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: 8-bit/K=1 and 16-bit/K=4 instances.
// Expected results are queued at launch and popped at done.
module tb_serial_subtractor;

  typedef struct packed {
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       bin8 = 1'b0;
  logic       busy8, done8, bout8, ovf8, zero8;
  logic [7:0] diff8;

  logic        start16 = 1'b0;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        bin16 = 1'b0;
  logic        busy16, done16, bout16, ovf16, zero16;
  logic [15:0] diff16;

  int tests = 0;
  int fails = 0;

  res_t q8[$];
  res_t q16[$];

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8), .K(1)) u8 (
    .clk  (clk),
    .rst  (rst),
    .start(start8),
    .a    (a8),
    .b    (b8),
    .bin  (bin8),
    .busy (busy8),
    .done (done8),
    .diff (diff8),
    .bout (bout8),
    .ovf  (ovf8),
    .zero (zero8)
  );

  serial_subtractor #(.WIDTH(16), .K(4)) u16 (
    .clk  (clk),
    .rst  (rst),
    .start(start16),
    .a    (a16),
    .b    (b16),
    .bin  (bin16),
    .busy (busy16),
    .done (done16),
    .diff (diff16),
    .bout (bout16),
    .ovf  (ovf16),
    .zero (zero16)
  );

  function automatic res_t model(input int w, input logic [15:0] a,
                                 input logic [15:0] b, input logic bin);
    res_t   r;
    longint m, ua, ub, sa, sb, full, s;
    m    = 64'sd1 <<< w;
    ua   = longint'(a) & (m - 1);
    ub   = longint'(b) & (m - 1);
    sa   = (ua >= m / 2) ? ua - m : ua;
    sb   = (ub >= m / 2) ? ub - m : ub;
    full = ua - ub - longint'(bin);
    s    = sa - sb - longint'(bin);
    r.diff = 16'(full & (m - 1));
    r.bout = (full < 0);
    r.ovf  = (s < -(m / 2)) || (s >= m / 2);
    r.zero = ((full & (m - 1)) == 0);
    return r;
  endfunction

  // Called just after a rising edge; returns just after the accept edge.
  task automatic launch8(input logic [7:0] a, input logic [7:0] b,
                         input logic bin);
    a8 = a;
    b8 = b;
    bin8 = bin;
    start8 = 1'b1;
    q8.push_back(model(8, {8'h00, a}, {8'h00, b}, bin));
    @(posedge clk);
    #1;
    start8 = 1'b0;
    a8 = ~a;
    b8 = a ^ b ^ 8'h5A;
    bin8 = ~bin;
  endtask

  task automatic wait_done8(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done8 && n < 30);
  endtask

  task automatic test_reset;
    #12;
    tests++;
    if ({busy8, done8, diff8, bout8, ovf8, zero8} !== 12'h000) begin
      fails++;
      $display("FAIL reset8: got busy=%b done=%b diff=%h bout=%b ovf=%b zero=%b, want all 0",
               busy8, done8, diff8, bout8, ovf8, zero8);
    end
    tests++;
    if ({busy16, done16, diff16, bout16, ovf16, zero16} !== 20'h00000) begin
      fails++;
      $display("FAIL reset16: got busy=%b done=%b diff=%h bout=%b ovf=%b zero=%b, want all 0",
               busy16, done16, diff16, bout16, ovf16, zero16);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    logic [16:0] vec [6];
    int   n;
    res_t exp, got;
    vec[0] = {8'h05, 8'h03, 1'b0};
    vec[1] = {8'h03, 8'h05, 1'b0};
    vec[2] = {8'h00, 8'h00, 1'b1};
    vec[3] = {8'h80, 8'h01, 1'b0};
    vec[4] = {8'h7F, 8'hFF, 1'b0};
    vec[5] = {8'h05, 8'h05, 1'b0};
    for (int i = 0; i < 6; i++) begin
      launch8(vec[i][16:9], vec[i][8:1], vec[i][0]);
      tests++;
      if (busy8 !== 1'b1) begin
        fails++;
        $display("FAIL basic_busy[%0d]: got %b want 1", i, busy8);
      end
      wait_done8(n);
      tests++;
      if (n != 8) begin
        fails++;
        $display("FAIL basic_latency[%0d]: got %0d edges want 8", i, n);
      end
      exp = q8.pop_front();
      got = '{diff: {8'h00, diff8}, bout: bout8, ovf: ovf8, zero: zero8};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL basic_result[%0d]: got diff=%h bout=%b ovf=%b zero=%b want diff=%h bout=%b ovf=%b zero=%b",
                 i, got.diff, got.bout, got.ovf, got.zero,
                 exp.diff, exp.bout, exp.ovf, exp.zero);
      end
      repeat (3) begin
        @(posedge clk);
        #1;
      end
      got = '{diff: {8'h00, diff8}, bout: bout8, ovf: ovf8, zero: zero8};
      tests++;
      if (got !== exp || done8 !== 1'b0) begin
        fails++;
        $display("FAIL basic_hold[%0d]: got diff=%h done=%b want diff=%h done=0",
                 i, got.diff, done8, exp.diff);
      end
    end
  endtask

  task automatic test_ignore_start;
    int   n;
    res_t exp, got;
    launch8(8'h40, 8'h13, 1'b1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    start8 = 1'b1;
    a8 = 8'hFF;
    b8 = 8'h01;
    bin8 = 1'b0;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    wait_done8(n);
    tests++;
    if (n != 5) begin
      fails++;
      $display("FAIL ignore_latency: got %0d edges after E3 want 5", n);
    end
    exp = q8.pop_front();
    got = '{diff: {8'h00, diff8}, bout: bout8, ovf: ovf8, zero: zero8};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL ignore_result: got diff=%h bout=%b ovf=%b zero=%b want diff=%h bout=%b ovf=%b zero=%b",
               got.diff, got.bout, got.ovf, got.zero,
               exp.diff, exp.bout, exp.ovf, exp.zero);
    end
    @(posedge clk);
    #1;
    tests++;
    if (busy8 !== 1'b0) begin
      fails++;
      $display("FAIL ignore_idle: got busy=%b want 0", busy8);
    end
  endtask

  task automatic test_back_to_back;
    int   n;
    res_t exp, got;
    launch8(8'h10, 8'h01, 1'b1);
    wait_done8(n);
    tests++;
    if (n != 8 || busy8 !== 1'b0) begin
      fails++;
      $display("FAIL b2b_first_done: got %0d edges busy=%b want 8 edges busy=0",
               n, busy8);
    end
    exp = q8.pop_front();
    got = '{diff: {8'h00, diff8}, bout: bout8, ovf: ovf8, zero: zero8};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL b2b_first: got diff=%h bout=%b ovf=%b want diff=%h bout=%b ovf=%b",
               got.diff, got.bout, got.ovf, exp.diff, exp.bout, exp.ovf);
    end
    launch8(8'h20, 8'h30, 1'b0);
    tests++;
    if (busy8 !== 1'b1) begin
      fails++;
      $display("FAIL b2b_accept: got busy=%b want 1", busy8);
    end
    wait_done8(n);
    tests++;
    if (n != 8) begin
      fails++;
      $display("FAIL b2b_latency: got %0d edges want 8", n);
    end
    exp = q8.pop_front();
    got = '{diff: {8'h00, diff8}, bout: bout8, ovf: ovf8, zero: zero8};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL b2b_second: got diff=%h bout=%b ovf=%b want diff=%h bout=%b ovf=%b",
               got.diff, got.bout, got.ovf, exp.diff, exp.bout, exp.ovf);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    int   n;
    bit   seen;
    res_t exp, got;
    launch8(8'h55, 8'h12, 1'b0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    #1;
    rst = 1'b1;
    #1;
    tests++;
    if ({busy8, done8, diff8, bout8, ovf8, zero8} !== 12'h000) begin
      fails++;
      $display("FAIL reset_mid: got busy=%b done=%b diff=%h bout=%b ovf=%b zero=%b want all 0",
               busy8, done8, diff8, bout8, ovf8, zero8);
    end
    void'(q8.pop_back());
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done8) seen = 1'b1;
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL reset_no_done: got done pulse after reset want none");
    end
    launch8(8'h05, 8'h05, 1'b0);
    wait_done8(n);
    tests++;
    if (n != 8) begin
      fails++;
      $display("FAIL reset_recover_latency: got %0d edges want 8", n);
    end
    exp = q8.pop_front();
    got = '{diff: {8'h00, diff8}, bout: bout8, ovf: ovf8, zero: zero8};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL reset_recover: got diff=%h zero=%b want diff=%h zero=%b",
               got.diff, got.zero, exp.diff, exp.zero);
    end
  endtask

  task automatic test_random16;
    int          n;
    res_t        exp, got;
    logic [15:0] ra, rb;
    logic        rbin;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rbin = 1'($urandom);
      if (i == 0) begin ra = 16'h0000; rb = 16'h0000; rbin = 1'b0; end
      if (i == 1) begin ra = 16'h0000; rb = 16'hFFFF; rbin = 1'b1; end
      if (i == 2) begin ra = 16'h8000; rb = 16'h0000; rbin = 1'b1; end
      if (i == 3) begin ra = 16'h7FFF; rb = 16'h8000; rbin = 1'b0; end
      a16 = ra;
      b16 = rb;
      bin16 = rbin;
      start16 = 1'b1;
      q16.push_back(model(16, ra, rb, rbin));
      @(posedge clk);
      #1;
      start16 = 1'b0;
      a16 = ~ra;
      b16 = ra;
      bin16 = ~rbin;
      n = 0;
      do begin
        @(posedge clk);
        #1;
        n++;
      end while (!done16 && n < 20);
      tests++;
      if (n != 4) begin
        fails++;
        $display("FAIL rand16_latency[%0d]: got %0d edges want 4", i, n);
      end
      exp = q16.pop_front();
      got = '{diff: diff16, bout: bout16, ovf: ovf16, zero: zero16};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL rand16[%0d] a=%h b=%h bin=%b: got diff=%h bout=%b ovf=%b zero=%b want diff=%h bout=%b ovf=%b zero=%b",
                 i, ra, rb, rbin, got.diff, got.bout, got.ovf, got.zero,
                 exp.diff, exp.bout, exp.ovf, exp.zero);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random16();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
